// File: rtl/mul_engine_if.sv
// mul_engine_if: eng_start/eng_done engine handshake bundle.
//   master (controller): drives eng_start, a, b; observes busy, eng_done, product
//   slave  (engine)    : observes eng_start, a, b; drives busy, eng_done, product
interface mul_engine_if #(
  parameter int unsigned W = 8
);
  logic             eng_start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             eng_done;
  logic [2*W-1:0]   product;

  modport master (
    output eng_start, a, b,
    input  busy, eng_done, product
  );

  modport slave (
    input  eng_start, a, b,
    output busy, eng_done, product
  );
endinterface

// File: rtl/mul_engine.sv
// mul_engine: iterative shift-add unsigned multiplier, responder side of the
// eng_start/eng_done handshake. Operands latched on the accepting edge, one
// multiplier bit retired per cycle, 2W-bit product presented with a held done.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mul_engine_if.slave (eng_start, a, b in; busy, eng_done, product out)
// Optional build macro: MUL_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running W cycles.
module mul_engine #(
  parameter int unsigned W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mul_engine_if.slave bus
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [PW-1:0]   product_q, product_d;

  logic [PW-1:0]   acc_sum_c;
  logic            finish_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    product_d = product_q;
    acc_sum_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    finish_c  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Accepting from DONE clears done on the same edge: no stale done.
        if (bus.eng_start) begin
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
          done_d   = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef MUL_EARLY_EXIT_EN
        finish_c = (cnt_d == CW'(W)) || (mplier_d == '0);
`else
        finish_c = (cnt_d == CW'(W));
`endif
        if (finish_c) begin
          product_d = acc_sum_c;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.eng_done = done_q;
  assign bus.product  = product_q;

endmodule

// File: tb/tb_mul_engine.sv
// tb_mul_engine: table-driven multiply vectors with an expected-product
// scoreboard, plus hand-written sequences for restart, start-during-run and
// mid-operation reset.
module tb_mul_engine;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  mul_engine_if #(.W(W)) bus ();

  mul_engine #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs [7];
  logic [2*W-1:0] exp_q [$];
  int             total;
  int             passed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < int'(W); i++) if (bv[i]) l = i + 1;
    return l;
`else
    return int'(W);
`endif
  endfunction

  // Issue one operation, optionally poke a second start while running, and
  // check latency, busy duration, product and hold behaviour.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] pv, input bit inject);
    int cyc;
    int busy_cyc;
    logic [2*W-1:0] expv;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.eng_start = 1'b1;
    exp_q.push_back(pv);
    @(posedge clk);
    @(negedge clk);
    bus.eng_start = 1'b0;
    check("accept_busy", 64'(bus.busy), 64'd1);
    check("accept_done_clear", 64'(bus.eng_done), 64'd0);
    cyc = 0;
    busy_cyc = 1;
    while (!bus.eng_done && cyc < 40) begin
      if (inject && cyc == 2) begin
        bus.eng_start = 1'b1;
        bus.a = 8'd1;
        bus.b = 8'd1;
      end else begin
        bus.eng_start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
    end
    bus.eng_start = 1'b0;
    if (!bus.eng_done) begin
      check("done_timeout", 64'(bus.eng_done), 64'd1);
      void'(exp_q.pop_front());
    end else begin
      expv = exp_q.pop_front();
      check("latency", 64'(cyc), 64'(exp_lat(bv)));
      check("busy_cycles", 64'(busy_cyc), 64'(exp_lat(bv)));
      check("product", 64'(bus.product), 64'(expv));
      repeat (2) @(negedge clk);
      check("done_held", 64'(bus.eng_done), 64'd1);
      check("product_held", 64'(bus.product), 64'(expv));
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    bus.eng_start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[3] = '{a: 8'd7,   b: 8'd5,   p: 16'd35};
    vecs[4] = '{a: 8'd9,   b: 8'd0,   p: 16'd0};
    vecs[5] = '{a: 8'd7,   b: 8'd128, p: 16'd896};
    vecs[6] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};

    // Reset, then idle with no start
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {bus.product, 46'd0, bus.busy, bus.eng_done}, 64'd0);
    end

    // Table vectors, issued back to back (later ones restart from DONE)
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
    end

    // Second start while running must be ignored
    run_op(8'd13, 8'd11, 16'd143, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.a = 8'd100;
    bus.b = 8'd3;
    bus.eng_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.eng_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.eng_done), 64'd0);
    check("abort_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {bus.product, 47'd0, bus.eng_done}, 64'd0);
    end
    run_op(8'd100, 8'd3, 16'd300, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
